div_seq: RTL and testbench

- Multi-cycle sequencer for DIV/DIVU.
- EX issues a request. This block latches the operands, iterates one quotient bit per cycle, and returns {remainder, quotient} for the HI/LO write path.
- Raises a stall request so the pipeline holds EX while the divide runs.
- Supports annulment when the instruction is flushed, e.g. on an exception.

---
 rtl/div_seq.sv | 131 +++++++++++++
 tb/tb_div_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} and stalls EX while busy.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q;
  logic                sgn1_q, sgn2_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic                neg1, neg2;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     partial;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1 = neg1 ? -opdata1_i : opdata1_i;
  assign mag2 = neg2 ? -opdata2_i : opdata2_i;

  // partial < 2*divisor, so a DATA_W+1 bit difference keeps a valid sign
  assign partial = {rem_q, quo_q[DATA_W-1]};
  assign diff    = partial - {1'b0, dvs_q};

  always_comb begin
    rem_d = partial[DATA_W-1:0];
    quo_d = {quo_q[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_d = diff[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  // quotient negated on sign mismatch, remainder follows dividend sign
  assign quo_fix = (sgn1_q ^ sgn2_q) ? -quo_q : quo_q;
  assign rem_fix = sgn1_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            sgn1_q  <= neg1;
            sgn2_q  <= neg2;
            dvs_q   <= mag2;
            quo_q   <= mag1;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state_q <= S_FREE;
          end else begin
            state_q  <= S_END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end else if (cnt_q == CNT_W'(DATA_W)) begin
            state_q  <= S_END;
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = (state_q == S_FREE && start_i && !annul_i)
                    | (state_q == S_BYZERO)
                    | (state_q == S_ON);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results,
// divide by zero, annulment and asynchronous reset.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks;
  int errors;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a request at a negedge and waits (bounded) for ready_o.
  // edges counts posedges from the accepting edge inclusive.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input bit scr,
                       output int edges, output int stalls,
                       output bit to);
    start_i      = 1'b1;
    annul_i      = 1'b0;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sg;
    #1;
    stalls = stallreq_o ? 1 : 0;
    edges  = 0;
    to     = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ready_o) begin
        to = 1'b0;
        break;
      end
      if (stallreq_o) stalls++;
      if (scr) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic release_start();
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (result_o !== 64'h0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h ready=%b stall=%b want 0/0/0",
               result_o, ready_o, stallreq_o);
    end
  endtask

  task automatic test_divu_basic();
    int e, s;
    bit to;
    logic [63:0] r;
    issue(32'h64, 32'h7, 1'b0, 1'b0, e, s, to);
    checks++;
    if (to || (e - 1) != 33) begin
      errors++;
      $display("FAIL latency_100_7: edges after accept=%0d timeout=%0b want 33",
               e - 1, to);
    end
    checks++;
    if (s != 34) begin
      errors++;
      $display("FAIL stall_cycles_100_7: got %0d want 34", s);
    end
    checks++;
    if (result_o !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL result_100_7: got %h want 000000020000000e", result_o);
    end
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_end: got %b want 0", stallreq_o);
    end
    r = result_o;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (ready_o !== 1'b1 || result_o !== r) begin
      errors++;
      $display("FAIL end_hold: ready=%b result=%h want 1/%h",
               ready_o, result_o, r);
    end
    release_start();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL end_release: ready=%b result=%h want 0/0",
               ready_o, result_o);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vs [6];
    logic [63:0] vx [6];
    int e, s;
    bit to;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'h2;        vs[0] = 1'b1;
    vx[0] = 64'hFFFFFFFF_FFFFFFFD;
    va[1] = 32'h7;        vb[1] = 32'hFFFFFFFE; vs[1] = 1'b1;
    vx[1] = 64'h00000001_FFFFFFFD;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'h1;        vs[2] = 1'b0;
    vx[2] = 64'h00000000_FFFFFFFF;
    va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF; vs[3] = 1'b1;
    vx[3] = 64'h00000000_80000000;
    va[4] = 32'h80000000; vb[4] = 32'hFFFFFFFF; vs[4] = 1'b0;
    vx[4] = 64'h80000000_00000000;
    va[5] = 32'hFFFFFF9C; vb[5] = 32'hFFFFFFF9; vs[5] = 1'b1;
    vx[5] = 64'hFFFFFFFE_0000000E;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vs[i], 1'b0, e, s, to);
      checks++;
      if (to || result_o !== vx[i]) begin
        errors++;
        $display("FAIL vector%0d: result=%h timeout=%0b want %h",
                 i, result_o, to, vx[i]);
      end
      release_start();
    end
  endtask

  task automatic test_divzero();
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = 1'b1;
    opdata1_i    = 32'h1234;
    opdata2_i    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL divzero: ready=%b result=%h stall=%b want 1/0/0",
               ready_o, result_o, stallreq_o);
    end
    release_start();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL divzero_release: ready=%b want 0", ready_o);
    end
  endtask

  task automatic test_annul();
    int e, s;
    bit to;
    bit seen;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h64;
    opdata2_i    = 32'h7;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_on: ready=%b stall=%b want 0/0",
               ready_o, stallreq_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    checks++;
    if (seen || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_hold: ready seen=%0b stall=%b want 0/0",
               seen, stallreq_o);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    issue(32'h9, 32'h3, 1'b0, 1'b0, e, s, to);
    checks++;
    if (to || result_o !== 64'h00000000_00000003) begin
      errors++;
      $display("FAIL after_annul_9_3: result=%h timeout=%0b want 3",
               result_o, to);
    end
    release_start();
  endtask

  task automatic test_scramble();
    int e, s;
    bit to;
    issue(32'h64, 32'h7, 1'b0, 1'b1, e, s, to);
    checks++;
    if (to || result_o !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL scramble_100_7: result=%h timeout=%0b want 000000020000000e",
               result_o, to);
    end
    opdata1_i = 32'h64;
    opdata2_i = 32'h7;
    release_start();
  endtask

  task automatic test_reset_mid();
    int e, s;
    bit to;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h64;
    opdata2_i    = 32'h7;
    repeat (6) @(posedge clk);
    #2;
    start_i = 1'b0;
    rst     = 1'b1;
    #1;
    checks++;
    if (result_o !== 64'h0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_on: result=%h ready=%b stall=%b want 0/0/0",
               result_o, ready_o, stallreq_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'hFFFFFFF9, 32'h2, 1'b1, 1'b0, e, s, to);
    #2;
    start_i = 1'b0;
    rst     = 1'b1;
    #1;
    checks++;
    if (to || result_o !== 64'h0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_end: result=%h ready=%b timeout=%0b want 0/0",
               result_o, ready_o, to);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_annul_free();
    start_i      = 1'b1;
    annul_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h64;
    opdata2_i    = 32'h7;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL start_annul_stall: got %b want 0", stallreq_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL start_annul_free: ready=%b stall=%b want 0/0",
               ready_o, stallreq_o);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divu_basic();
    test_vectors();
    test_divzero();
    test_annul();
    test_scramble();
    test_start_annul_free();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
